// File: rtl/noise_pkg.sv
// noise_pkg: shared constants, mode enum and LFSR tap-mask lookup
// for the noise_gen voice-path noise source.
package noise_pkg;

  localparam logic [31:0] DEFAULT_SEED = 32'd1;

  localparam int SHORT_TAP_HI = 7;
  localparam int SHORT_TAP_LO = 6;

  typedef enum logic {
    NOISE_FULL  = 1'b0,
    NOISE_SHORT = 1'b1
  } noise_mode_e;

  // Mask bit n-1 set means state bit n is a feedback tap.
  function automatic logic [31:0] tap_mask(input int bits);
    logic [31:0] m;
    m = 32'h0;
    case (bits)
      16:      m = 32'h0000_D008;
      24:      m = 32'h00E1_0000;
      31:      m = 32'h4800_0000;
      32:      m = 32'h8020_0003;
      default: m = 32'h0;
    endcase
    return m;
  endfunction

  function automatic bit legal_bits(input int bits);
    return (bits == 16) || (bits == 24) ||
           (bits == 31) || (bits == 32);
  endfunction

endpackage

// File: rtl/noise_rate_div.sv
// noise_rate_div: step-rate divider. tick is high on enabled cycles
// where the count equals rate. Ports: clk, reset, enable, clear, rate, tick.
module noise_rate_div
  import noise_pkg::*;
#(
  parameter int RATE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 clear,
  input  logic [RATE_BITS-1:0] rate,
  output logic                 tick
);

  logic [RATE_BITS-1:0] cnt_q;
  logic [RATE_BITS-1:0] cnt_d;

  assign tick = enable && (cnt_q == rate);

  // A count above a lowered rate simply wraps round to meet it.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/noise_gen.sv
// noise_gen: Fibonacci LFSR noise source with rate divider, seeding,
// short (127) mode, lock-up recovery and a valid/ready sample port.
// Ports: clk, reset, enable, seed_load, seed, mode, rate,
// sample_data/valid/ready, overrun, clear_overrun, lockup.
module noise_gen
  import noise_pkg::*;
#(
  parameter int LFSR_BITS = 31,
  parameter int WIDTH     = 16,
  parameter int RATE_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 seed_load,
  input  logic [LFSR_BITS-1:0] seed,
  input  logic                 mode,
  input  logic [RATE_BITS-1:0] rate,
  output logic [WIDTH-1:0]     sample_data,
  output logic                 sample_valid,
  input  logic                 sample_ready,
  output logic                 overrun,
  input  logic                 clear_overrun,
  output logic                 lockup
);

  localparam logic [31:0] MASK32 = tap_mask(LFSR_BITS);
  localparam logic [LFSR_BITS-1:0] MASK =
    MASK32[LFSR_BITS-1:0];
  localparam logic [LFSR_BITS-1:0] SEED0 =
    DEFAULT_SEED[LFSR_BITS-1:0];

  generate
    if (!legal_bits(LFSR_BITS)) begin : g_bad_len
      $error("noise_gen: LFSR_BITS must be 16, 24, 31 or 32");
    end
    if (WIDTH > LFSR_BITS) begin : g_bad_width
      $error("noise_gen: WIDTH must not exceed LFSR_BITS");
    end
  endgenerate

  logic [LFSR_BITS-1:0] state_q, state_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovr_q, ovr_d;
  logic                 lock_q, lock_d;

  logic                 tick;
  logic                 step;
  logic                 lock_c;
  logic [LFSR_BITS-1:0] next_c;
  noise_mode_e          mode_e;

  assign mode_e = noise_mode_e'(mode);

  // A seed load in a tick cycle swallows that step.
  assign step = tick && !seed_load;

  noise_rate_div #(
    .RATE_BITS(RATE_BITS)
  ) u_div (
    .clk   (clk),
    .reset (reset),
    .enable(enable),
    .clear (seed_load),
    .rate  (rate),
    .tick  (tick)
  );

  always_comb begin
    lock_c = 1'b0;
    next_c = state_q;
    if (mode_e == NOISE_SHORT) begin
      if (state_q[SHORT_TAP_HI-1:0] == '0) begin
        lock_c = 1'b1;
        next_c = {state_q[LFSR_BITS-2:0], 1'b1};
      end else begin
        next_c = {state_q[LFSR_BITS-2:0],
                  state_q[SHORT_TAP_HI-1] ^
                  state_q[SHORT_TAP_LO-1]};
      end
    end else begin
      if (state_q == '0) begin
        lock_c = 1'b1;
        next_c = SEED0;
      end else begin
        next_c = {state_q[LFSR_BITS-2:0],
                  ^(state_q & MASK)};
      end
    end
  end

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    lock_d  = step && lock_c;
    if (seed_load) begin
      state_d = (seed == '0) ? SEED0 : seed;
    end else if (step) begin
      state_d = next_c;
    end
    if (step) begin
      data_d  = next_c[WIDTH-1:0];
      valid_d = 1'b1;
    end else if (valid_q && sample_ready) begin
      valid_d = 1'b0;
    end
    // An overrun event beats a simultaneous clear.
    if (step && valid_q && !sample_ready) begin
      ovr_d = 1'b1;
    end else if (clear_overrun) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= SEED0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
      lock_q  <= lock_d;
    end
  end

  assign sample_data  = data_q;
  assign sample_valid = valid_q;
  assign overrun      = ovr_q;
  assign lockup       = lock_q;

endmodule

// File: tb/tb_noise_gen.sv
// tb_noise_gen: self-checking bench for noise_gen (LFSR_BITS=16)
// against an arithmetic reference model of the LFSR.
module tb_noise_gen;

  localparam int LB = 16;
  localparam int W  = 16;
  localparam int RB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          enable;
  logic          seed_load;
  logic [LB-1:0] seed;
  logic          mode;
  logic [RB-1:0] rate;
  logic [W-1:0]  sample_data;
  logic          sample_valid;
  logic          sample_ready;
  logic          overrun;
  logic          clear_overrun;
  logic          lockup;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  noise_gen #(
    .LFSR_BITS(LB),
    .WIDTH    (W),
    .RATE_BITS(RB)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .enable       (enable),
    .seed_load    (seed_load),
    .seed         (seed),
    .mode         (mode),
    .rate         (rate),
    .sample_data  (sample_data),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .clear_overrun(clear_overrun),
    .lockup       (lockup)
  );

  // Reference: 16-bit state as an integer, taps 16,15,13,4;
  // short mode taps 7,6 with lock-up forcing bit 1.
  function automatic int unsigned model_next(
    input int unsigned s, input bit sh, output bit lk);
    int unsigned fb;
    lk = 1'b0;
    if (sh) begin
      if (s % 128 == 0) begin
        lk = 1'b1;
        fb = 1;
      end else begin
        fb = ((s >> 6) ^ (s >> 5)) & 1;
      end
    end else begin
      if (s == 0) begin
        lk = 1'b1;
        return 1;
      end
      fb = ((s >> 15) ^ (s >> 14) ^ (s >> 12) ^ (s >> 3)) & 1;
    end
    return (s * 2 + fb) % 65536;
  endfunction

  task automatic step_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enable = 1'b0;
    seed_load = 1'b0;
    mode = 1'b0;
    sample_ready = 1'b0;
    clear_overrun = 1'b0;
    seed = '0;
    rate = '0;
    @(posedge clk);
    #2 reset = 1'b0;
  endtask

  task automatic load_seed(input logic [LB-1:0] s);
    seed = s;
    seed_load = 1'b1;
    step_edge();
    seed_load = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    enable = 1'b1;
    seed_load = 1'b0;
    mode = 1'b0;
    sample_ready = 1'b0;
    clear_overrun = 1'b0;
    seed = '0;
    rate = '0;
    for (int p = 0; p < 2; p++) begin
      if (p == 0) #1;
      else step_edge();
      vectors++;
      if (sample_data !== 16'h0) begin
        miscompares++;
        $display("FAIL reset_data p%0d got %h exp 0000", p, sample_data);
      end
      vectors++;
      if (sample_valid !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_valid p%0d got %b exp 0", p, sample_valid);
      end
      vectors++;
      if (overrun !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_overrun p%0d got %b exp 0", p, overrun);
      end
      vectors++;
      if (lockup !== 1'b0) begin
        miscompares++;
        $display("FAIL reset_lockup p%0d got %b exp 0", p, lockup);
      end
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_sequence();
    logic [15:0] exp4 [4];
    int unsigned ms;
    bit lk;
    bit r;
    bit ovr;
    exp4[0] = 16'h0002;
    exp4[1] = 16'h0004;
    exp4[2] = 16'h0008;
    exp4[3] = 16'h0011;
    do_reset();
    load_seed(16'h0001);
    rate = '0;
    enable = 1'b1;
    sample_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step_edge();
      vectors++;
      if (sample_data !== exp4[i] || sample_valid !== 1'b1) begin
        miscompares++;
        $display("FAIL seq16_%0d got %h/%b exp %h/1",
                 i, sample_data, sample_valid, exp4[i]);
      end
    end
    ms = 32'h11;
    ovr = 1'b0;
    for (int i = 0; i < 100; i++) begin
      r = 1'($urandom_range(0, 1));
      sample_ready = r;
      step_edge();
      ms = model_next(ms, 1'b0, lk);
      if (!r) ovr = 1'b1;
      vectors++;
      if (sample_data !== 16'(ms) || overrun !== ovr) begin
        miscompares++;
        $display("FAIL rand_ready_%0d got %h/%b exp %h/%b",
                 i, sample_data, overrun, 16'(ms), ovr);
      end
    end
  endtask

  task automatic test_period();
    int unsigned ms;
    bit lk;
    int errs;
    int zeros;
    int lks;
    logic [6:0] hist [254];
    do_reset();
    load_seed(16'hACE1);
    enable = 1'b1;
    sample_ready = 1'b1;
    ms = 32'hACE1;
    errs = 0;
    zeros = 0;
    lks = 0;
    for (int i = 0; i < 65535; i++) begin
      step_edge();
      ms = model_next(ms, 1'b0, lk);
      if (sample_data !== 16'(ms)) errs++;
      if (sample_data == 16'h0) zeros++;
      if (lockup !== 1'b0) lks++;
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL full_track got %0d bad steps exp 0", errs);
    end
    vectors++;
    if (sample_data !== 16'hACE1) begin
      miscompares++;
      $display("FAIL full_period got %h exp ace1", sample_data);
    end
    vectors++;
    if (zeros != 0) begin
      miscompares++;
      $display("FAIL full_zero got %0d exp 0", zeros);
    end
    vectors++;
    if (lks != 0) begin
      miscompares++;
      $display("FAIL full_lockup got %0d exp 0", lks);
    end
    enable = 1'b0;
    load_seed(16'hACE1);
    mode = 1'b1;
    enable = 1'b1;
    ms = 32'hACE1;
    errs = 0;
    for (int i = 0; i < 254; i++) begin
      step_edge();
      ms = model_next(ms, 1'b1, lk);
      if (sample_data !== 16'(ms)) errs++;
      hist[i] = sample_data[6:0];
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL short_track got %0d bad steps exp 0", errs);
    end
    errs = 0;
    for (int i = 0; i < 127; i++) begin
      if (hist[i] !== hist[i+127]) errs++;
    end
    vectors++;
    if (errs != 0) begin
      miscompares++;
      $display("FAIL short_period got %0d diffs exp 0", errs);
    end
    mode = 1'b0;
  endtask

  task automatic test_rate(input int r);
    int unsigned ms;
    bit lk;
    bit ev;
    int n;
    int bad;
    do_reset();
    rate = RB'(r);
    sample_ready = 1'b1;
    enable = 1'b1;
    ms = 1;
    for (int k = 1; k <= 4 * (r + 1); k++) begin
      step_edge();
      ev = (k % (r + 1) == 0);
      if (ev) ms = model_next(ms, 1'b0, lk);
      vectors++;
      if (sample_valid !== ev || (ev && sample_data !== 16'(ms))) begin
        miscompares++;
        $display("FAIL rate%0d_k%0d got %b/%h exp %b/%h",
                 r, k, sample_valid, sample_data, ev, 16'(ms));
      end
    end
    enable = 1'b0;
    bad = 0;
    for (int k = 0; k < 5; k++) begin
      step_edge();
      if (sample_valid !== 1'b0) bad++;
    end
    vectors++;
    if (bad != 0 || sample_data !== 16'(ms)) begin
      miscompares++;
      $display("FAIL rate%0d_frozen got %0d/%h exp 0/%h",
               r, bad, sample_data, 16'(ms));
    end
    enable = 1'b1;
    n = 0;
    while (sample_valid !== 1'b1 && n <= 20) begin
      step_edge();
      n++;
    end
    ms = model_next(ms, 1'b0, lk);
    vectors++;
    if (n != r + 1 || sample_data !== 16'(ms)) begin
      miscompares++;
      $display("FAIL rate%0d_resume got %0d/%h exp %0d/%h",
               r, n, sample_data, r + 1, 16'(ms));
    end
  endtask

  task automatic test_overrun();
    int unsigned ms;
    bit lk;
    logic [15:0] s0;
    do_reset();
    s0 = 16'($urandom_range(1, 65535));
    load_seed(s0);
    ms = s0;
    rate = 16'd1;
    enable = 1'b1;
    sample_ready = 1'b0;
    step_edge();
    step_edge();
    ms = model_next(ms, 1'b0, lk);
    vectors++;
    if (sample_valid !== 1'b1 || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_first got %b/%b exp 1/0", sample_valid, overrun);
    end
    step_edge();
    step_edge();
    ms = model_next(ms, 1'b0, lk);
    vectors++;
    if (overrun !== 1'b1 || sample_data !== 16'(ms)) begin
      miscompares++;
      $display("FAIL ovr_second got %b/%h exp 1/%h",
               overrun, sample_data, 16'(ms));
    end
    step_edge();
    clear_overrun = 1'b1;
    step_edge();
    ms = model_next(ms, 1'b0, lk);
    vectors++;
    if (overrun !== 1'b1 || sample_data !== 16'(ms)) begin
      miscompares++;
      $display("FAIL ovr_clear_race got %b/%h exp 1/%h",
               overrun, sample_data, 16'(ms));
    end
    step_edge();
    clear_overrun = 1'b0;
    vectors++;
    if (overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL ovr_clear got %b exp 0", overrun);
    end
    sample_ready = 1'b1;
    step_edge();
    ms = model_next(ms, 1'b0, lk);
    vectors++;
    if (overrun !== 1'b0 || sample_valid !== 1'b1 ||
        sample_data !== 16'(ms)) begin
      miscompares++;
      $display("FAIL ovr_accept got %b/%b/%h exp 0/1/%h",
               overrun, sample_valid, sample_data, 16'(ms));
    end
  endtask

  task automatic test_seed_zero();
    int unsigned s1;
    bit lk;
    logic [15:0] s0;
    do_reset();
    do begin
      s0 = 16'($urandom_range(2, 65535));
      s1 = model_next(s0, 1'b0, lk);
    end while (s1 == 2);
    load_seed(s0);
    rate = 16'd2;
    enable = 1'b1;
    sample_ready = 1'b0;
    for (int k = 0; k < 5; k++) step_edge();
    seed = '0;
    seed_load = 1'b1;
    step_edge();
    seed_load = 1'b0;
    vectors++;
    if (sample_data !== 16'(s1) || sample_valid !== 1'b1 ||
        overrun !== 1'b0 || lockup !== 1'b0) begin
      miscompares++;
      $display("FAIL seed0_hold got %h/%b/%b/%b exp %h/1/0/0",
               sample_data, sample_valid, overrun, lockup, 16'(s1));
    end
    step_edge();
    step_edge();
    vectors++;
    if (sample_data !== 16'(s1) || overrun !== 1'b0) begin
      miscompares++;
      $display("FAIL seed0_nostep got %h/%b exp %h/0",
               sample_data, overrun, 16'(s1));
    end
    step_edge();
    vectors++;
    if (sample_data !== 16'h0002 || overrun !== 1'b1) begin
      miscompares++;
      $display("FAIL seed0_step got %h/%b exp 0002/1",
               sample_data, overrun);
    end
  endtask

  task automatic test_lockup_reset();
    int unsigned ms;
    bit lk;
    do_reset();
    mode = 1'b1;
    load_seed(16'h0100);
    enable = 1'b1;
    sample_ready = 1'b1;
    step_edge();
    vectors++;
    if (lockup !== 1'b1 || sample_data !== 16'h0201) begin
      miscompares++;
      $display("FAIL short_lock got %b/%h exp 1/0201",
               lockup, sample_data);
    end
    ms = 32'h0201;
    for (int k = 0; k < 4; k++) begin
      step_edge();
      ms = model_next(ms, 1'b1, lk);
      vectors++;
      if (lockup !== 1'b0 || sample_data !== 16'(ms)) begin
        miscompares++;
        $display("FAIL short_after_%0d got %b/%h exp 0/%h",
                 k, lockup, sample_data, 16'(ms));
      end
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (sample_data !== 16'h0 || sample_valid !== 1'b0 ||
        overrun !== 1'b0 || lockup !== 1'b0) begin
      miscompares++;
      $display("FAIL async_reset got %h/%b/%b/%b exp 0000/0/0/0",
               sample_data, sample_valid, overrun, lockup);
    end
    @(posedge clk);
    #2 reset = 1'b0;
    step_edge();
    vectors++;
    if (sample_data !== 16'h0002 || sample_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_resume got %h/%b exp 0002/1",
               sample_data, sample_valid);
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_period();
    test_rate(3);
    test_rate(int'($urandom_range(0, 5)));
    test_overrun();
    test_seed_zero();
    test_lockup_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/noise_gen.md
# noise_gen

Parametrised pseudo-random noise source for the synth voice path. A Fibonacci LFSR of selectable length is advanced by a programmable rate divider, supports run-time seeding and a short-period "metallic" mode, and recovers automatically from lock-up. Samples go to the mixer over a valid/ready handshake, with a sticky overrun flag.

## Interface
- LFSR_BITS, 31: LFSR length; legal values 16, 24, 31, 32; any other value is an elaboration error.
- WIDTH, 16: sample width; must be ≤ LFSR_BITS.
- RATE_BITS, 16: width of the rate divider.
- clk  in  1  single system clock
- reset  in  1  asynchronous, active-high reset
- enable  in  1  gates the divider and LFSR stepping; the handshake stays live
- seed_load  in  1  one-cycle strobe; loads `seed`
- seed  in  LFSR_BITS  seed value
- mode  in  1  0 = full-length, 1 = short (period 127)
- rate  in  RATE_BITS  step period minus one, in enabled cycles
- sample_data  out  WIDTH  low WIDTH bits of the LFSR state after the latest step
- sample_valid  out  1  sample available
- sample_ready  in  1  consumer accepts the sample
- overrun  out  1  sticky: a step overwrote an unconsumed sample
- clear_overrun  in  1  clears overrun
- lockup  out  1  one-cycle pulse when a lock-up correction is applied

## Operation
- State register bits are numbered [LFSR_BITS:1]. Each step shifts left; the feedback bit enters bit 1.
- Full-mode feedback is the XOR of the package tap set:
  - 16 → bits 16, 15, 13, 4
  - 24 → bits 24, 23, 22, 17
  - 31 → bits 31, 28
  - 32 → bits 32, 22, 2, 1
- Short-mode feedback is bit 7 XOR bit 6. Bits 7:1 then cycle with period 127; the upper bits are shifted along.
- Lock-up correction:
  - Full mode: if the state is all-zero at a step, DEFAULT_SEED is loaded instead of shifting.
  - Short mode: if bits 7:1 are all-zero at a step, bit 1 is forced to 1.
  - In both cases lockup pulses for one cycle.
- seed_load takes priority over a step in the same cycle.
  - Loads `seed`, or DEFAULT_SEED if `seed` is 0.
  - Clears the divider count.
  - Leaves sample_data and sample_valid unchanged.
- A mode change takes effect at the next step; the state is not altered.
- Handshake on a step:
  - sample_data gets the new state's low WIDTH bits and sample_valid is set to 1.
  - If sample_valid was 1 and sample_ready was 0 in that cycle, overrun is set.
  - A step with valid and ready both high is a clean accept plus a new sample: no overrun.
- With no step, sample_valid clears when sample_valid and sample_ready are both high.
- clear_overrun clears overrun. A simultaneous overrun event wins and overrun stays 1.

## Timing
- Reset values:
  - LFSR state = DEFAULT_SEED (1).
  - Divider count = 0.
  - sample_data = 0, sample_valid = 0, overrun = 0, lockup = 0.
- Step tick: tick = enable && (div_cnt == rate).
  - On a tick edge the count returns to 0; otherwise it increments while enable is high.
  - Steps occur every rate+1 enabled cycles; rate = 0 gives a step on every enabled cycle.
  - If rate is lowered below the current count, the count continues to wrap at 2^RATE_BITS, then hits the match.
- Latency: the edge where tick is high updates the state, sample_data and sample_valid together, so the new sample is visible the cycle after the tick.
- enable low freezes the count and the state.
- Asynchronous reset mid-run returns everything to reset values immediately; the first step after release occurs rate+1 enabled cycles later.

## Structure
- Package noise_pkg:
  - DEFAULT_SEED.
  - The mode enum (NOISE_FULL, NOISE_SHORT).
  - A constant function returning the tap mask for a given LFSR_BITS.
  - SHORT_TAP_HI = 7 and SHORT_TAP_LO = 6.
- Sub-module noise_rate_div:
  - Parameter RATE_BITS.
  - Inputs clk, reset, enable, clear, rate; output tick.
  - Instantiated once.
- The top level holds the LFSR state, the feedback/lock-up logic and the handshake/overrun registers.

## Test plan
- LFSR_BITS=16, reset, seed_load with seed=0x0001, rate=0, enable=1, sample_ready=1 → sample_data sequence 0x0002, 0x0004, 0x0008, 0x0011, with sample_valid high from the first step.
- LFSR_BITS=16, full mode, 65535 steps after loading 0xACE1 → the state returns to 0xACE1, never hits zero, and lockup never pulses. Short mode from the same seed → bits 7:1 repeat every 127 steps.
- rate=3, sample_ready=1 → sample_valid high at one cycle in four. Dropping enable for 5 cycles delays the next step by exactly 5 cycles.
- sample_ready=0 across two steps → overrun=1 and sample_data holds the second sample. clear_overrun coincident with a third unaccepted step → overrun stays 1.
- seed_load with seed=0, with a tick in the same cycle → state = DEFAULT_SEED, no step, divider cleared, sample_valid unchanged.
- Short mode with seed 0x0100 (bits 7:1 zero) → at the next step lockup pulses and bit 1 is forced to 1. Asserting reset mid-sequence → all outputs 0 asynchronously, and the state resumes from DEFAULT_SEED after release.
